// File: rtl/ex_ctrl_seq_if.sv
// ex_ctrl_seq_if: ID/EX control-word handshake in, registered execute controls out.
// master = upstream driver / EX-MEM side, slave = ex_ctrl_seq.
interface ex_ctrl_seq_if #(
  parameter int unsigned EX_W      = 4,
  parameter int unsigned ALU_CNT_W = 3
);
  localparam int unsigned SCNT_W = 16;

  logic                 in_valid;
  logic                 in_ready;
  logic [EX_W-1:0]      ex;
  logic [1:0]           jump_t;
  logic                 slt;
  logic                 sign_bit;
  logic                 lui;
  logic                 flush;
  logic                 out_ready;
  logic                 out_valid;
  logic                 m2_3_cnt;
  logic                 m2_4_cnt;
  logic                 m2_5_cnt;
  logic                 m2_6_cnt;
  logic [1:0]           m4_1_cnt;
  logic [ALU_CNT_W-1:0] alu_cnt;
  logic                 stall;
  logic [SCNT_W-1:0]    stall_cnt;

  modport master (
    output in_valid, ex, jump_t, slt, sign_bit, lui, flush, out_ready,
    input  in_ready, out_valid, m2_3_cnt, m2_4_cnt, m2_5_cnt, m2_6_cnt,
           m4_1_cnt, alu_cnt, stall, stall_cnt
  );

  modport slave (
    input  in_valid, ex, jump_t, slt, sign_bit, lui, flush, out_ready,
    output in_ready, out_valid, m2_3_cnt, m2_4_cnt, m2_5_cnt, m2_6_cnt,
           m4_1_cnt, alu_cnt, stall, stall_cnt
  );
endinterface

// File: rtl/ex_ctrl_seq.sv
// ex_ctrl_seq: registered execute-stage control decode with multi-cycle op sequencing.
// Define EX_CTRL_PERF_EN to build the saturating stall-cycle counter driven on stall_cnt.
module ex_ctrl_seq #(
  parameter int unsigned EX_W      = 4,
  parameter int unsigned ALU_CNT_W = 3,
  parameter int unsigned MUL_LAT   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ex_ctrl_seq_if.slave  bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SCNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_MULTI = 1'b1
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_out_valid;
  logic                 r_m2_3;
  logic                 r_m2_4;
  logic                 r_m2_5;
  logic                 r_m2_6;
  logic [1:0]           r_m4_1;
  logic [ALU_CNT_W-1:0] r_alu_cnt;

  logic w_in_ready;
  logic w_accept;
  logic w_consume;
  logic w_multi;
  logic w_stall;

  // rst_n gating keeps in_ready low while the block is held in reset
  assign w_in_ready = rst_n && (r_state == S_IDLE) && (!r_out_valid || bus.out_ready)
                      && !bus.flush;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_consume  = r_out_valid && bus.out_ready;
  assign w_multi    = bus.ex[EX_W-1];
  assign w_stall    = (r_state == S_MULTI) || (bus.in_valid && !w_in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_m2_3      <= 1'b0;
      r_m2_4      <= 1'b0;
      r_m2_5      <= 1'b0;
      r_m2_6      <= 1'b0;
      r_m4_1      <= 2'b00;
      r_alu_cnt   <= '0;
    end else if (bus.flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_m2_6    <= bus.sign_bit;
            r_m2_5    <= bus.ex[2];
            r_m2_4    <= (bus.jump_t != 2'b01);
            r_m2_3    <= (bus.jump_t == 2'b11);
            r_m4_1    <= bus.slt ? 2'b10 : (bus.lui ? 2'b01 : 2'b00);
            r_alu_cnt <= bus.ex[ALU_CNT_W-1:0];
            // accept implies any held output is consumed this cycle
            if (w_multi) begin
              r_state     <= S_MULTI;
              r_cnt       <= CNT_LOAD;
              r_out_valid <= 1'b0;
            end else begin
              r_out_valid <= 1'b1;
            end
          end else if (w_consume) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MULTI: begin
          if (r_cnt == '0) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef EX_CTRL_PERF_EN
  logic [SCNT_W-1:0] r_stall_cnt;

  // saturating count of stalled cycles; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = SCNT_W'(0);
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.stall     = w_stall;
  assign bus.out_valid = r_out_valid;
  assign bus.m2_3_cnt  = r_m2_3;
  assign bus.m2_4_cnt  = r_m2_4;
  assign bus.m2_5_cnt  = r_m2_5;
  assign bus.m2_6_cnt  = r_m2_6;
  assign bus.m4_1_cnt  = r_m4_1;
  assign bus.alu_cnt   = r_alu_cnt;

endmodule

// File: tb/tb_ex_ctrl_seq.sv
// tb_ex_ctrl_seq: directed plus randomized stimulus for ex_ctrl_seq against a
// cycle-level behavioural model (busy-cycles-remaining, expected output word).
module tb_ex_ctrl_seq;
  localparam int unsigned EX_W      = 4;
  localparam int unsigned ALU_CNT_W = 3;
  localparam int unsigned MUL_LAT   = 4;
`ifdef EX_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_ctrl_seq_if #(.EX_W(EX_W), .ALU_CNT_W(ALU_CNT_W)) bus ();

  ex_ctrl_seq #(.EX_W(EX_W), .ALU_CNT_W(ALU_CNT_W), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model: busy = cycles still to wait for a multi-cycle result
  int m_busy, m_ov, m_scnt;
  int m_m2_3, m_m2_4, m_m2_5, m_m2_6, m_m4_1, m_alu;

  logic       v_valid, v_flush, v_ordy, v_slt, v_sign, v_lui;
  logic [3:0] v_ex;
  logic [1:0] v_jt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ov = 0; m_scnt = 0;
    m_m2_3 = 0; m_m2_4 = 0; m_m2_5 = 0; m_m2_6 = 0; m_m4_1 = 0; m_alu = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_out_valid"}, 32'(bus.out_valid), 32'(m_ov));
    check({pfx, "_alu_cnt"},   32'(bus.alu_cnt),   32'(m_alu));
    check({pfx, "_m2_3"},      32'(bus.m2_3_cnt),  32'(m_m2_3));
    check({pfx, "_m2_4"},      32'(bus.m2_4_cnt),  32'(m_m2_4));
    check({pfx, "_m2_5"},      32'(bus.m2_5_cnt),  32'(m_m2_5));
    check({pfx, "_m2_6"},      32'(bus.m2_6_cnt),  32'(m_m2_6));
    check({pfx, "_m4_1"},      32'(bus.m4_1_cnt),  32'(m_m4_1));
    check({pfx, "_stall_cnt"}, 32'(bus.stall_cnt), 32'(m_scnt));
  endtask

  task automatic set_in(input logic valid, input logic [3:0] ex, input logic [1:0] jt,
                        input logic slt, input logic lui, input logic sign,
                        input logic flush, input logic ordy);
    v_valid = valid; v_ex = ex; v_jt = jt; v_slt = slt; v_lui = lui;
    v_sign = sign; v_flush = flush; v_ordy = ordy;
  endtask

  // one clock: drive, check handshake, advance model, check registered outputs
  task automatic cycle(input string pfx);
    bit exp_rdy, exp_stall, acc;
    @(negedge clk);
    bus.in_valid = v_valid; bus.ex = v_ex; bus.jump_t = v_jt; bus.slt = v_slt;
    bus.lui = v_lui; bus.sign_bit = v_sign; bus.flush = v_flush; bus.out_ready = v_ordy;
    #1;
    exp_rdy   = (m_busy == 0) && (m_ov == 0 || v_ordy) && !v_flush;
    exp_stall = (m_busy > 0) || (v_valid && !exp_rdy);
    check({pfx, "_in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    check({pfx, "_stall"},    32'(bus.stall),    32'(exp_stall));
    if (PERF && exp_stall && m_scnt < 65535) m_scnt++;
    acc = v_valid && exp_rdy;
    if (v_flush) begin
      m_busy = 0; m_ov = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_ov = 1;
    end else if (acc) begin
      m_m2_6 = int'(v_sign);
      m_m2_5 = (int'(v_ex) >> 2) % 2;
      m_m2_4 = (v_jt == 2'd1) ? 0 : 1;
      m_m2_3 = (v_jt == 2'd3) ? 1 : 0;
      m_m4_1 = v_slt ? 2 : (v_lui ? 1 : 0);
      m_alu  = int'(v_ex) % 8;
      if (v_ex >= 4'd8) begin
        m_busy = MUL_LAT - 1; m_ov = 0;
      end else begin
        m_ov = 1;
      end
    end else if (m_ov == 1 && v_ordy) begin
      m_ov = 0;
    end
    @(posedge clk);
    #1;
    check_outputs(pfx);
  endtask

  initial begin
    model_reset();
    set_in(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.in_valid = 1'b0; bus.ex = '0; bus.jump_t = '0; bus.slt = 1'b0;
    bus.lui = 1'b0; bus.sign_bit = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // first decoded word
    set_in(1'b1, 4'b0011, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("tp1");
    check("tp1_ov_const",  32'(bus.out_valid), 32'd1);
    check("tp1_alu_const", 32'(bus.alu_cnt),   32'd3);
    check("tp1_m4_const",  32'(bus.m4_1_cnt),  32'd2);
    set_in(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("tp1_idle");

    // multi-cycle op with upstream still presenting words
    set_in(1'b1, 4'b1000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle("mc_acc");
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 4'b0101, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 4) v_valid = 1'b0;
      cycle("mc_run");
    end
    set_in(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("mc_drain");

    // backpressure hold then release
    set_in(1'b1, 4'b0110, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("bp_acc");
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 4'b0001, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("bp_hold");
    end
    check("bp_hold_alu", 32'(bus.alu_cnt), 32'd6);
    set_in(1'b1, 4'b0001, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("bp_rel");

    // flush during MULTI
    set_in(1'b1, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("fl_acc");
    set_in(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("fl_c1");
    set_in(1'b1, 4'b0010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle("fl_flush");
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("fl_after");
    end

    // back-to-back single-cycle ops
    set_in(1'b1, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("b2b0");
    check("b2b0_m2_4", 32'(bus.m2_4_cnt), 32'd0);
    v_jt = 2'b10;
    cycle("b2b1");
    check("b2b1_m2_4", 32'(bus.m2_4_cnt), 32'd1);
    v_jt = 2'b00;
    cycle("b2b2");
    check("b2b2_ov", 32'(bus.out_valid), 32'd1);

    // asynchronous reset mid-MULTI
    set_in(1'b1, 4'b1010, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle("ar_acc");
    set_in(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("ar_c1");
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("ar_out_valid", 32'(bus.out_valid), 32'd0);
    check("ar_stall",     32'(bus.stall),     32'd0);
    check("ar_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("ar_alu_cnt",   32'(bus.alu_cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v_valid = ($urandom_range(0, 9) < 7);
      v_ex    = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) v_ex = v_ex | 4'b1000;
      v_jt    = 2'($urandom_range(0, 3));
      v_slt   = 1'($urandom_range(0, 1));
      v_lui   = 1'($urandom_range(0, 1));
      v_sign  = 1'($urandom_range(0, 1));
      v_flush = ($urandom_range(0, 19) == 0);
      v_ordy  = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
